id_ex_operand_stage: RTL
========================

Name: id_ex_operand_stage

Overview:
- Pipeline register between decode and the execute-stage ALU.
- Captures decoded operands, opcode and destination info through a valid/ready handshake.
- Resolves EX/MEM and MEM/WB forwarding and immediate selection, then drives the ALU's opc/lhs/rhs.
- Detects load-use hazards and inserts bubbles. Supports flush on taken branch/jump.

Parameters:
- N, 32, datapath width
- AW, 5, register address width

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  decode presents an instruction
- in_ready  output  1  stage accepts this cycle
- in_opc  input  3  ALU opcode (ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101, SLTU 111)
- in_rs1, in_rs2  input  AW  source register addresses
- in_rs1_data, in_rs2_data  input  N  register-file read data
- in_imm  input  N  sign-extended immediate
- in_alu_src_imm  input  1  rhs = immediate when 1
- in_rd  input  AW  destination register
- in_reg_write  input  1  instruction writes rd
- in_mem_read  input  1  instruction is a load
- flush  input  1  kill the held instruction and any capture this cycle
- out_ready  input  1  ALU stage consumes this cycle
- exmem_reg_write, exmem_rd, exmem_res  input  1/AW/N  EX/MEM producer
- memwb_reg_write, memwb_rd, memwb_res  input  1/AW/N  MEM/WB producer
- out_valid  output  1  held instruction valid
- opc  output  3  to ALU
- lhs, rhs  output  N  to ALU
- store_data  output  N  forwarded rs2 value, independent of immediate select
- out_rd, out_reg_write, out_mem_read  output  AW/1/1  passed down

Behaviour:
- Reset (async, rst=1):
  - All registers clear; out_valid=0.
  - opc, out_rd, out_reg_write and out_mem_read are 0.
  - lhs, rhs and store_data reflect zeroed registers; they are 0 unless forwarding matches rd 0, which is impossible.
  - Reset mid-transfer discards the held instruction.
- Load-use hazard:
  - load_use = out_valid & out_mem_read & out_rd!=0 & in_valid & (in_rs1==out_rd | (in_rs2==out_rd & !in_alu_src_imm)).
  - An immediate-form instruction does not depend on rs2 through rhs. However, if it is a store, the hazard also applies when in_rs2 matches. Decode signals this by driving in_alu_src_imm=0 for the check, so the check stays as written.
- in_ready = (!out_valid | out_ready) & !load_use. This is combinational.
- Capture: when in_valid & in_ready & !flush, all in_* fields register next edge and out_valid=1. Latency is 1 cycle.
- Drain without capture: when out_valid & out_ready and no capture, out_valid=0 next edge. On load_use this is the bubble.
- Hold: when out_valid & !out_ready, every register holds its value.
- Flush: has priority over everything else. Next edge out_valid=0, control bits are cleared and no capture occurs.
- Forwarding is combinational on the registered addresses, so it tracks producers while holding. Operand src1 uses stored rs1 and data:
  - If exmem_reg_write & exmem_rd!=0 & exmem_rd==rs1: use exmem_res (highest priority).
  - Else if memwb_reg_write & memwb_rd!=0 & memwb_rd==rs1: use memwb_res.
  - Else: use the stored data.
- Operand src2 is resolved identically using rs2.
- Output muxing:
  - lhs = src1.
  - rhs = stored alu_src_imm ? stored imm : src2.
  - store_data = src2.
- Register x0 is never forwarded. Stored data for x0 passes through unchanged.
- Simultaneous drain and capture in the same cycle: the new instruction replaces the old one; out_valid stays 1.

Test Plan:
- Reset then push ADD, rs1=1 (data 5), rs2=2 (data 7), out_ready=1.
  - Next cycle: out_valid=1, opc=000, lhs=5, rhs=7.
  - One cycle later, with no input: out_valid=0.
- Hold instruction with rs1=3 while exmem_rd=3, exmem_res=0x10, memwb_rd=3, memwb_res=0x20, both writes set.
  - lhs=0x10.
  - Drop exmem_reg_write: lhs=0x20.
  - Set rs1=0 with producers rd=0: lhs = stored data.
- Load to rd=4 is held; next instruction has rs1=4.
  - in_ready=0.
  - With out_ready=1, out_valid=0 next cycle (bubble).
  - Dependent instruction is captured the following cycle.
- out_ready=0 for 3 cycles with in_valid=1.
  - in_ready=0 throughout and outputs stable.
  - Release out_ready: new instruction captured the same edge; out_valid stays 1.
- flush=1 together with in_valid=1 and in_ready=1.
  - Next cycle out_valid=0 and out_reg_write=0.
- Assert rst asynchronously mid-hold, between clock edges.
  - out_valid=0 immediately.
  - Stays 0 after rst release until a new capture.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
//   Pipeline register sitting between instruction decode and the execute-stage
//   ALU. It captures one decoded instruction through a valid/ready handshake,
//   resolves EX/MEM and MEM/WB forwarding against the held source registers,
//   selects the immediate where requested and presents opc/lhs/rhs to the ALU.
//   A load followed by a dependent instruction is stalled one cycle (bubble),
//   and a flush from a taken branch/jump kills the held instruction.
//
// Ports
//   clk, rst                      rising-edge clock, async active-high reset
//   in_valid / in_ready           decode-side handshake
//   in_opc, in_rs1, in_rs2        opcode and source register addresses
//   in_rs1_data, in_rs2_data      register-file read data
//   in_imm, in_alu_src_imm        sign-extended immediate and rhs select
//   in_rd, in_reg_write           destination register and write enable
//   in_mem_read                   instruction is a load
//   flush                         kill held instruction and any capture
//   out_ready                     ALU stage consumes this cycle
//   exmem_* / memwb_*             forwarding producers (write, rd, result)
//   out_valid                     held instruction valid
//   opc, lhs, rhs                 ALU operation and operands
//   store_data                    forwarded rs2 value (ignores imm select)
//   out_rd, out_reg_write,
//   out_mem_read                  control passed down the pipe
module id_ex_operand_stage #(
  parameter int N  = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_opc,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [N-1:0]  in_rs1_data,
  input  logic [N-1:0]  in_rs2_data,
  input  logic [N-1:0]  in_imm,
  input  logic          in_alu_src_imm,
  input  logic [AW-1:0] in_rd,
  input  logic          in_reg_write,
  input  logic          in_mem_read,
  input  logic          flush,
  input  logic          out_ready,
  input  logic          exmem_reg_write,
  input  logic [AW-1:0] exmem_rd,
  input  logic [N-1:0]  exmem_res,
  input  logic          memwb_reg_write,
  input  logic [AW-1:0] memwb_rd,
  input  logic [N-1:0]  memwb_res,
  output logic          out_valid,
  output logic [2:0]    opc,
  output logic [N-1:0]  lhs,
  output logic [N-1:0]  rhs,
  output logic [N-1:0]  store_data,
  output logic [AW-1:0] out_rd,
  output logic          out_reg_write,
  output logic          out_mem_read
);

  logic          valid_q;
  logic [2:0]    opc_q;
  logic [AW-1:0] rs1_q;
  logic [AW-1:0] rs2_q;
  logic [N-1:0]  rs1_data_q;
  logic [N-1:0]  rs2_data_q;
  logic [N-1:0]  imm_q;
  logic          alu_src_imm_q;
  logic [AW-1:0] rd_q;
  logic          reg_write_q;
  logic          mem_read_q;

  logic          load_use;
  logic          capture;
  logic [N-1:0]  src1;
  logic [N-1:0]  src2;

  // Picks the youngest producer writing the requested register; x0 is never
  // forwarded so its stored value always passes through.
  function automatic logic [N-1:0] resolve(
    input logic [AW-1:0] addr,
    input logic [N-1:0]  stored,
    input logic          ex_we,
    input logic [AW-1:0] ex_rd,
    input logic [N-1:0]  ex_res,
    input logic          wb_we,
    input logic [AW-1:0] wb_rd,
    input logic [N-1:0]  wb_res
  );
    logic [N-1:0] value;
    value = stored;
    if (ex_we && (ex_rd != '0) && (ex_rd == addr)) begin
      value = ex_res;
    end else if (wb_we && (wb_rd != '0) && (wb_rd == addr)) begin
      value = wb_res;
    end
    return value;
  endfunction

  // A held load whose result the incoming instruction needs cannot be
  // forwarded in time, so the incoming instruction is refused for one cycle.
  // Stores arrive with in_alu_src_imm=0, which keeps their rs2 in the check.
  always_comb begin
    load_use = valid_q && mem_read_q && (rd_q != '0) && in_valid &&
               ((in_rs1 == rd_q) || ((in_rs2 == rd_q) && !in_alu_src_imm));
  end

  assign in_ready = (!valid_q || out_ready) && !load_use;
  assign capture  = in_valid && in_ready && !flush;

  // Stage register. Flush beats capture; a capture may replace an instruction
  // draining the same cycle; otherwise a consumed instruction just drains and
  // an unconsumed one holds every field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= 1'b0;
      opc_q         <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rs1_data_q    <= '0;
      rs2_data_q    <= '0;
      imm_q         <= '0;
      alu_src_imm_q <= 1'b0;
      rd_q          <= '0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
    end else if (flush) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else if (capture) begin
      valid_q       <= 1'b1;
      opc_q         <= in_opc;
      rs1_q         <= in_rs1;
      rs2_q         <= in_rs2;
      rs1_data_q    <= in_rs1_data;
      rs2_data_q    <= in_rs2_data;
      imm_q         <= in_imm;
      alu_src_imm_q <= in_alu_src_imm;
      rd_q          <= in_rd;
      reg_write_q   <= in_reg_write;
      mem_read_q    <= in_mem_read;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Forwarding works on the registered addresses, so a held instruction keeps
  // tracking producers that advance underneath it.
  always_comb begin
    src1 = resolve(rs1_q, rs1_data_q, exmem_reg_write, exmem_rd, exmem_res,
                   memwb_reg_write, memwb_rd, memwb_res);
    src2 = resolve(rs2_q, rs2_data_q, exmem_reg_write, exmem_rd, exmem_res,
                   memwb_reg_write, memwb_rd, memwb_res);
  end

  assign out_valid     = valid_q;
  assign opc           = opc_q;
  assign lhs           = src1;
  assign rhs           = alu_src_imm_q ? imm_q : src2;
  assign store_data    = src2;
  assign out_rd        = rd_q;
  assign out_reg_write = reg_write_q;
  assign out_mem_read  = mem_read_q;

endmodule
